// File: rtl/team_06_delay_mem_sched.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// team_06_delay_mem_sched
//
// Scheduler for the single-port delay-line SRAM shared by the echo and reverb
// effect paths. For every accepted audio sample tick it writes the incoming
// sample at wr_ptr, reads the echo tap and then the reverb tap behind it, and
// presents both taps to the effect mixer. After every reset release, and on
// request, it zeroes the entire memory with a sweep.
//
// Ports
//   clk             system clock
//   rst             asynchronous, active-low reset
//   sample_tick     one-cycle pulse per audio sample
//   mic_sample      live mic audio, sampled together with sample_tick
//   state           control FSM state (2'b01 TALK, 2'b00 LIST)
//   current_effect  selected effect (3'b001 ECHO, 3'b011 REVERB)
//   clear_req       level request to zero the delay memory
//   mem_en/mem_we   memory enable / write enable
//   mem_addr        memory address
//   mem_wdata       memory write data
//   mem_rdata       memory read data, valid the cycle after a read
//   echo_tap        delayed sample for the echo path
//   reverb_tap      delayed sample for the reverb path
//   taps_valid      one-cycle pulse: taps updated
//   busy            high whenever the scheduler is not idle
//   overrun         sticky: a sample_tick arrived mid-sequence and was dropped
//   clear_done      one-cycle pulse at the end of a clear sweep
// -----------------------------------------------------------------------------
module team_06_delay_mem_sched #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 8,
  parameter int ECHO_DLY   = 1500,
  parameter int REVERB_DLY = 700
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_tick,
  input  logic [DATA_W-1:0] mic_sample,
  input  logic [1:0]        state,
  input  logic [2:0]        current_effect,
  input  logic              clear_req,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] echo_tap,
  output logic [DATA_W-1:0] reverb_tap,
  output logic              taps_valid,
  output logic              busy,
  output logic              overrun,
  output logic              clear_done
);

  localparam logic [1:0]        CTL_TALK   = 2'b01;
  localparam logic [2:0]        EFF_ECHO   = 3'b001;
  localparam logic [2:0]        EFF_REVERB = 3'b011;
  localparam logic [ADDR_W-1:0] ECHO_OFS   = ADDR_W'(ECHO_DLY);
  localparam logic [ADDR_W-1:0] REV_OFS    = ADDR_W'(REVERB_DLY);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;

  typedef enum logic [2:0] {
    S_CLEAR   = 3'd0,
    S_IDLE    = 3'd1,
    S_WRITE   = 3'd2,
    S_RD_ECHO = 3'd3,
    S_RD_REV  = 3'd4,
    S_CAPT    = 3'd5
  } sched_e;

  // Tap address behind the write pointer; wraps modulo the memory depth.
  function automatic logic [ADDR_W-1:0] tap_addr(input logic [ADDR_W-1:0] ptr,
                                                 input logic [ADDR_W-1:0] dly);
    return ptr - dly;
  endfunction

  sched_e              fsm_q, fsm_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic                overrun_q, overrun_d;
  logic                clear_done_q, clear_done_d;
  logic                taps_valid_q, taps_valid_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   echo_tap_q, echo_tap_d;
  logic [DATA_W-1:0]   reverb_tap_q, reverb_tap_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   echo_hold_q, echo_hold_d;

  logic                mem_en_c;
  logic                mem_we_c;
  logic [ADDR_W-1:0]   mem_addr_c;
  logic [DATA_W-1:0]   mem_wdata_c;

  // ---------------------------------------------------------------------------
  // Next-state and sequence control
  // ---------------------------------------------------------------------------
  always_comb begin
    fsm_d        = fsm_q;
    clr_cnt_d    = clr_cnt_q;
    wr_ptr_d     = wr_ptr_q;
    overrun_d    = overrun_q;
    clear_done_d = 1'b0;
    taps_valid_d = 1'b0;
    echo_tap_d   = echo_tap_q;
    reverb_tap_d = reverb_tap_q;
    wdata_d      = wdata_q;
    echo_hold_d  = echo_hold_q;

    case (fsm_q)
      S_CLEAR: begin
        // Ticks arriving here are dropped without flagging overrun.
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_ADDR) begin
          fsm_d        = S_IDLE;
          wr_ptr_d     = '0;
          overrun_d    = 1'b0;
          clear_done_d = 1'b1;
        end
      end
      S_IDLE: begin
        // A clear request wins over a tick in the same cycle.
        if (clear_req) begin
          fsm_d     = S_CLEAR;
          clr_cnt_d = '0;
        end else if (sample_tick) begin
          // Writing silence while listening drains the delay line.
          wdata_d = (state == CTL_TALK) ? mic_sample : '0;
          fsm_d   = S_WRITE;
        end
      end
      S_WRITE: begin
        fsm_d = S_RD_ECHO;
      end
      S_RD_ECHO: begin
        fsm_d = S_RD_REV;
      end
      S_RD_REV: begin
        // Echo read data returns this cycle.
        echo_hold_d = mem_rdata;
        fsm_d       = S_CAPT;
      end
      S_CAPT: begin
        // Reverb read data returns this cycle; the output register holds it.
        echo_tap_d   = (current_effect == EFF_ECHO)   ? echo_hold_q : '0;
        reverb_tap_d = (current_effect == EFF_REVERB) ? mem_rdata   : '0;
        taps_valid_d = 1'b1;
        wr_ptr_d     = wr_ptr_q + 1'b1;
        fsm_d        = S_IDLE;
      end
      default: begin
        fsm_d     = S_CLEAR;
        clr_cnt_d = '0;
      end
    endcase

    if (sample_tick && ((fsm_q == S_WRITE) || (fsm_q == S_RD_ECHO) ||
                        (fsm_q == S_RD_REV) || (fsm_q == S_CAPT))) begin
      overrun_d = 1'b1;
    end

    busy_d = (fsm_d != S_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Memory-side decode from the current state
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_en_c    = 1'b0;
    mem_we_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    case (fsm_q)
      S_CLEAR: begin
        mem_en_c   = 1'b1;
        mem_we_c   = 1'b1;
        mem_addr_c = clr_cnt_q;
      end
      S_WRITE: begin
        mem_en_c    = 1'b1;
        mem_we_c    = 1'b1;
        mem_addr_c  = wr_ptr_q;
        mem_wdata_c = wdata_q;
      end
      S_RD_ECHO: begin
        mem_en_c   = 1'b1;
        mem_addr_c = tap_addr(wr_ptr_q, ECHO_OFS);
      end
      S_RD_REV: begin
        mem_en_c   = 1'b1;
        mem_addr_c = tap_addr(wr_ptr_q, REV_OFS);
      end
      default: begin
      end
    endcase
  end

  // The reset state decodes as a write, so the memory port is forced quiet
  // while reset is held; the sweep begins once reset releases.
  assign mem_en    = rst & mem_en_c;
  assign mem_we    = rst & mem_we_c;
  assign mem_addr  = rst ? mem_addr_c  : '0;
  assign mem_wdata = rst ? mem_wdata_c : '0;

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q        <= S_CLEAR;
      clr_cnt_q    <= '0;
      wr_ptr_q     <= '0;
      overrun_q    <= 1'b0;
      clear_done_q <= 1'b0;
      taps_valid_q <= 1'b0;
      busy_q       <= 1'b1;
      echo_tap_q   <= '0;
      reverb_tap_q <= '0;
    end else begin
      fsm_q        <= fsm_d;
      clr_cnt_q    <= clr_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      overrun_q    <= overrun_d;
      clear_done_q <= clear_done_d;
      taps_valid_q <= taps_valid_d;
      busy_q       <= busy_d;
      echo_tap_q   <= echo_tap_d;
      reverb_tap_q <= reverb_tap_d;
    end
  end

  always_ff @(posedge clk) begin
    wdata_q     <= wdata_d;
    echo_hold_q <= echo_hold_d;
  end

  assign echo_tap   = echo_tap_q;
  assign reverb_tap = reverb_tap_q;
  assign taps_valid = taps_valid_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;
  assign clear_done = clear_done_q;

endmodule

// File: tb/tb_team_06_delay_mem_sched.sv
`timescale 1ns/1ps
module tb_team_06_delay_mem_sched;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int EDLY  = 3;
  localparam int RDLY  = 2;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          sample_tick = 1'b0;
  logic [DW-1:0] mic_sample = '0;
  logic [1:0]    state = 2'b01;
  logic [2:0]    current_effect = 3'b001;
  logic          clear_req = 1'b0;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] echo_tap, reverb_tap;
  logic          taps_valid, busy, overrun, clear_done;

  team_06_delay_mem_sched #(
    .ADDR_W(AW), .DATA_W(DW), .ECHO_DLY(EDLY), .REVERB_DLY(RDLY)
  ) dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .mic_sample(mic_sample),
    .state(state), .current_effect(current_effect), .clear_req(clear_req),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .echo_tap(echo_tap), .reverb_tap(reverb_tap),
    .taps_valid(taps_valid), .busy(busy), .overrun(overrun), .clear_done(clear_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Single-port synchronous SRAM seen by the scheduler.
  logic [DW-1:0] sram [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) sram[i] = 8'($urandom);
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata      <= sram[mem_addr];
    end
  end

  // Reference model: the delay line as a plain array of past samples.
  typedef struct { int echo; int rev; int cyc; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int   model_mem [DEPTH];
  int   model_ptr = 0;
  bit   exp_ovr = 1'b0;

  int errors = 0;
  int checks = 0;
  int last_echo = -1;
  int last_rev  = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: every taps_valid pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst && taps_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL taps_valid_unexpected: got pulse at cycle %0d, expected none", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("echo_tap", echo_tap, mon_e.echo);
        chk("reverb_tap", reverb_tap, mon_e.rev);
        chk("tap_latency_cycle", cyc, mon_e.cyc);
        last_echo = echo_tap;
        last_rev  = reverb_tap;
      end
    end
  end

  task automatic check_reset_vals();
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_busy", busy, 1);
    chk("rst_taps_valid", taps_valid, 0);
    chk("rst_echo_tap", echo_tap, 0);
    chk("rst_reverb_tap", reverb_tap, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_clear_done", clear_done, 0);
  endtask

  // Entered while the sweep shows address 0; leaves one cycle after clear_done.
  task automatic check_sweep();
    for (int i = 0; i < DEPTH; i++) begin
      chk("sweep_en_we", {mem_en, mem_we}, 2'b11);
      chk("sweep_addr", mem_addr, i);
      chk("sweep_wdata", mem_wdata, 0);
      chk("sweep_busy", busy, 1);
      chk("sweep_no_done", clear_done, 0);
      @(negedge clk);
    end
    chk("clear_done_pulse", clear_done, 1);
    chk("busy_after_sweep", busy, 0);
    chk("overrun_after_sweep", overrun, 0);
    @(negedge clk);
    chk("clear_done_single", clear_done, 0);
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 0;
    model_ptr = 0;
    exp_ovr   = 1'b0;
  endtask

  task automatic do_clear_req();
    @(negedge clk);
    chk("idle_before_clear", busy, 0);
    chk("overrun_before_clear", overrun, exp_ovr);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    check_sweep();
  endtask

  // One sample tick from IDLE; dup raises a second tick two cycles later.
  task automatic do_tick(input int mic, input bit talk, input int eff, input bit dup);
    int p, ea, ra, w;
    exp_t e;
    @(negedge clk);
    chk("idle_before_tick", busy, 0);
    sample_tick    = 1'b1;
    mic_sample     = mic[7:0];
    state          = talk ? 2'b01 : 2'b00;
    current_effect = eff[2:0];
    p  = model_ptr;
    w  = talk ? (mic & 255) : 0;
    model_mem[p] = w;
    ea = (p + DEPTH - EDLY) % DEPTH;
    ra = (p + DEPTH - RDLY) % DEPTH;
    e.echo = (eff == 1) ? model_mem[ea] : 0;
    e.rev  = (eff == 3) ? model_mem[ra] : 0;
    e.cyc  = cyc + 5;
    exp_q.push_back(e);
    model_ptr = (p + 1) % DEPTH;
    @(negedge clk);
    sample_tick = 1'b0;
    mic_sample  = 8'($urandom);
    chk("write_en_we", {mem_en, mem_we}, 2'b11);
    chk("write_addr", mem_addr, p);
    chk("write_data", mem_wdata, w);
    @(negedge clk);
    chk("rd_echo_en_we", {mem_en, mem_we}, 2'b10);
    chk("rd_echo_addr", mem_addr, ea);
    if (dup) begin
      sample_tick = 1'b1;
      exp_ovr     = 1'b1;
    end
    @(negedge clk);
    sample_tick = 1'b0;
    chk("rd_rev_en_we", {mem_en, mem_we}, 2'b10);
    chk("rd_rev_addr", mem_addr, ra);
    @(negedge clk);
    chk("capt_mem_en", mem_en, 0);
    chk("capt_busy", busy, 1);
    chk("overrun_flag", overrun, exp_ovr);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int eff_tab [8] = '{1, 3, 1, 3, 0, 2, 5, 7};
    // Reset and the automatic sweep after release.
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst = 1'b1;
    #1;
    check_sweep();

    // Echo: the fourth tick hears the first sample.
    do_tick(10, 1, 1, 0);
    do_tick(20, 1, 1, 0);
    do_tick(30, 1, 1, 0);
    do_tick(40, 1, 1, 0);
    @(negedge clk); #1;
    chk("echo_4th_value", last_echo, 10);
    chk("echo_4th_reverb_zero", last_rev, 0);

    // LIST writes silence; the echo of that slot is silent later.
    do_tick(99, 0, 1, 0);
    do_tick(5, 1, 1, 0);
    do_tick(6, 1, 1, 0);
    do_tick(7, 1, 1, 0);
    @(negedge clk); #1;
    chk("echo_after_list", last_echo, 0);

    // Overrun: second tick two cycles after the first is dropped.
    do_tick(11, 1, 1, 1);
    repeat (3) @(negedge clk);
    chk("overrun_sticky", overrun, 1);
    do_clear_req();

    // Reverb: third tick hears the first sample; run on past the wrap.
    do_tick(10, 1, 3, 0);
    do_tick(20, 1, 3, 0);
    do_tick(30, 1, 3, 0);
    @(negedge clk); #1;
    chk("reverb_3rd_value", last_rev, 10);
    chk("reverb_3rd_echo_zero", last_echo, 0);
    for (int i = 0; i < 14; i++) do_tick(int'($urandom_range(1, 255)), 1, 3, 0);

    // clear_req and sample_tick together: the clear wins.
    @(negedge clk);
    chk("idle_before_combo", busy, 0);
    clear_req   = 1'b1;
    sample_tick = 1'b1;
    mic_sample  = 8'd55;
    state       = 2'b01;
    @(negedge clk);
    clear_req   = 1'b0;
    sample_tick = 1'b0;
    check_sweep();

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      do_tick(int'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0),
              eff_tab[$urandom_range(0, 7)], 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    repeat (2) @(negedge clk);

    // Reset during RD_ECHO aborts the sequence at once.
    @(negedge clk);
    sample_tick = 1'b1;
    state       = 2'b01;
    mic_sample  = 8'd77;
    @(negedge clk);
    sample_tick = 1'b0;
    @(negedge clk);
    chk("pre_abort_rd_echo", {mem_en, mem_we}, 2'b10);
    #2;
    rst = 1'b0;
    #1;
    check_reset_vals();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_sweep();
    do_tick(21, 1, 1, 0);
    do_tick(22, 1, 3, 0);

    repeat (8) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
